// File: rtl/alu_control_unit.sv
// ALU control decoder with registered Control word, plus a multi-cycle
// shift-add / restoring-divide engine that owns the HI/LO registers.
module alu_control_unit #(
    parameter int WIDTH = 32
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic             Valid,
    input  logic [1:0]       ALUOp,
    input  logic [5:0]       Funct,
    input  logic [WIDTH-1:0] Data1,
    input  logic [WIDTH-1:0] Data2,
    output logic [3:0]       Control,
    output logic             CtlValid,
    output logic             IllegalFunct,
    output logic             Stall,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             MdDone,
    output logic             DivZero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [3:0]         r_control;
    logic               r_ctl_valid;
    logic               r_illegal;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_operand;
    logic [CW-1:0]      r_count;
    logic               r_is_div;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_div_zero;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic [3:0]         w_ctl;
    logic               w_illegal;
    logic               w_is_md;
    logic               w_md_div;
    logic               w_md_signed;
    logic               w_accept;
    logic               w_md_start;
    logic               w_alu_accept;
    logic               w_div_zero_start;
    logic [WIDTH-1:0]   w_abs1;
    logic [WIDTH-1:0]   w_abs2;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [2*WIDTH:0]   w_div_shift;
    logic [WIDTH:0]     w_div_trial;
    logic [2*WIDTH-1:0] w_div_next;
    logic [2*WIDTH-1:0] w_step;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;
    logic [2*WIDTH-1:0] w_fix;

    always_comb begin
        w_ctl     = 4'b0010;
        w_illegal = 1'b0;
        w_is_md   = 1'b0;
        case (ALUOp)
            2'b00: w_ctl = 4'b0010;
            2'b01: w_ctl = 4'b0110;
            2'b11: w_ctl = 4'b0001;
            default: begin
                case (Funct)
                    6'b100000: w_ctl = 4'b0010;
                    6'b100010: w_ctl = 4'b0110;
                    6'b100100: w_ctl = 4'b0000;
                    6'b100101: w_ctl = 4'b0001;
                    6'b101010: w_ctl = 4'b0111;
                    6'b100111: w_ctl = 4'b1100;
                    6'b100110: w_ctl = 4'b1101;
                    6'b011000, 6'b011001, 6'b011010, 6'b011011: w_is_md = 1'b1;
                    default:   w_illegal = 1'b1;
                endcase
            end
        endcase
    end

    // Funct[1] selects divide, Funct[0] selects the unsigned variant.
    assign w_md_div         = Funct[1];
    assign w_md_signed      = ~Funct[0];
    assign w_accept         = Valid && !Stall;
    assign w_md_start       = w_accept && w_is_md;
    assign w_alu_accept     = w_accept && !w_is_md;
    assign w_div_zero_start = w_md_start && w_md_div && (Data2 == '0);

    assign w_abs1 = (w_md_signed && Data1[WIDTH-1]) ? -Data1 : Data1;
    assign w_abs2 = (w_md_signed && Data2[WIDTH-1]) ? -Data2 : Data2;

    // Multiply: low half of r_acc holds the multiplier, shifted out as the product shifts in.
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_operand} : '0);
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Divide: {remainder, quotient} shifts left; a non-negative trial keeps the subtraction.
    assign w_div_shift = {r_acc, 1'b0};
    assign w_div_trial = w_div_shift[2*WIDTH:WIDTH] - {1'b0, r_operand};
    assign w_div_next  = w_div_trial[WIDTH] ? w_div_shift[2*WIDTH-1:0]
                                            : {w_div_trial[WIDTH-1:0], w_div_shift[WIDTH-1:1], 1'b1};
    assign w_step      = r_is_div ? w_div_next : w_mul_next;

    assign w_quot = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem  = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
    assign w_fix  = r_is_div ? {w_rem, w_quot} : (r_neg_q ? -r_acc : r_acc);

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // DONE behaves like IDLE for acceptance so an op presented there is never lost.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_md_start) begin
                    w_state_next = w_div_zero_start ? S_DONE : S_RUN;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_RUN:   if (r_count == CW'(1)) w_state_next = S_FIX;
            S_FIX:   w_state_next = S_DONE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        Stall   = (r_state == S_RUN) || (r_state == S_FIX);
        MdDone  = (r_state == S_DONE);
        DivZero = (r_state == S_DONE) && r_div_zero;
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_control   <= 4'b0010;
            r_ctl_valid <= 1'b0;
            r_illegal   <= 1'b0;
            r_acc       <= '0;
            r_operand   <= '0;
            r_count     <= '0;
            r_is_div    <= 1'b0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_div_zero  <= 1'b0;
            r_hi        <= '0;
            r_lo        <= '0;
        end else begin
            r_ctl_valid <= w_alu_accept;
            r_illegal   <= w_alu_accept && w_illegal;
            if (w_alu_accept) begin
                r_control <= w_ctl;
            end
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_md_start) begin
                        r_acc      <= {{WIDTH{1'b0}}, w_abs1};
                        r_operand  <= w_abs2;
                        r_count    <= CW'(WIDTH);
                        r_is_div   <= w_md_div;
                        r_neg_q    <= w_md_signed && (Data1[WIDTH-1] ^ Data2[WIDTH-1]);
                        r_neg_r    <= w_md_signed && Data1[WIDTH-1];
                        r_div_zero <= w_div_zero_start;
                        if (w_div_zero_start) begin
                            r_hi <= Data1;
                            r_lo <= '1;
                        end
                    end
                end
                S_RUN: begin
                    r_acc   <= w_step;
                    r_count <= r_count - CW'(1);
                end
                S_FIX: begin
                    r_hi <= w_fix[2*WIDTH-1:WIDTH];
                    r_lo <= w_fix[WIDTH-1:0];
                end
                default: ;
            endcase
        end
    end

    assign Control      = r_control;
    assign CtlValid     = r_ctl_valid;
    assign IllegalFunct = r_illegal;
    assign Hi           = r_hi;
    assign Lo           = r_lo;

endmodule

// File: tb/tb_alu_control_unit.sv
// Directed bench for alu_control_unit: decode table, illegal funct, mult/div
// results and timing, stall behaviour, and asynchronous reset mid-operation.
module tb_alu_control_unit;

    localparam int W = 32;

    logic         Clock   = 1'b0;
    logic         Reset_n = 1'b0;
    logic         Valid   = 1'b0;
    logic [1:0]   ALUOp   = '0;
    logic [5:0]   Funct   = '0;
    logic [W-1:0] Data1   = '0;
    logic [W-1:0] Data2   = '0;
    logic [3:0]   Control;
    logic         CtlValid;
    logic         IllegalFunct;
    logic         Stall;
    logic [W-1:0] Hi;
    logic [W-1:0] Lo;
    logic         MdDone;
    logic         DivZero;

    alu_control_unit #(.WIDTH(W)) dut (
        .Clock(Clock), .Reset_n(Reset_n), .Valid(Valid), .ALUOp(ALUOp), .Funct(Funct),
        .Data1(Data1), .Data2(Data2), .Control(Control), .CtlValid(CtlValid),
        .IllegalFunct(IllegalFunct), .Stall(Stall), .Hi(Hi), .Lo(Lo),
        .MdDone(MdDone), .DivZero(DivZero)
    );

    always #5 Clock = ~Clock;

    typedef struct packed {
        logic [3:0] ctl;
        logic       ill;
    } dec_t;

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } md_t;

    dec_t dec_q[$];
    md_t  md_q[$];
    int   compared   = 0;
    int   mismatched = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic dec_t dec_model(input logic [1:0] op, input logic [5:0] fn);
        dec_t d;
        d.ctl = 4'b0010;
        d.ill = 1'b0;
        case (op)
            2'b01: d.ctl = 4'b0110;
            2'b11: d.ctl = 4'b0001;
            2'b10: begin
                case (fn)
                    6'b100000: d.ctl = 4'b0010;
                    6'b100010: d.ctl = 4'b0110;
                    6'b100100: d.ctl = 4'b0000;
                    6'b100101: d.ctl = 4'b0001;
                    6'b101010: d.ctl = 4'b0111;
                    6'b100111: d.ctl = 4'b1100;
                    6'b100110: d.ctl = 4'b1101;
                    default:   d.ill = 1'b1;
                endcase
            end
            default: d.ctl = 4'b0010;
        endcase
        return d;
    endfunction

    function automatic md_t md_model(input logic [5:0] fn, input logic [W-1:0] d1, input logic [W-1:0] d2);
        md_t          m;
        longint       a;
        longint       b;
        logic [63:0]  r;
        logic [63:0]  q;
        a = longint'($signed(d1));
        b = longint'($signed(d2));
        m.dz = 1'b0;
        r = '0;
        q = '0;
        case (fn)
            6'b011000: r = 64'(a * b);
            6'b011001: r = {32'b0, d1} * {32'b0, d2};
            6'b011010: begin
                if (d2 != 0) begin
                    q = 64'(a / b);
                    r = {64'(a % b)};
                    r = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (d2 != 0) begin
                    r = {d1 % d2, d1 / d2};
                end
            end
        endcase
        m.hi = r[63:32];
        m.lo = r[31:0];
        if (fn[1] && d2 == 0) begin
            m.hi = d1;
            m.lo = '1;
            m.dz = 1'b1;
        end
        return m;
    endfunction

    task automatic alu_op(input logic [1:0] op, input logic [5:0] fn, input string tag);
        dec_t e;
        @(negedge Clock);
        Valid = 1'b1; ALUOp = op; Funct = fn;
        dec_q.push_back(dec_model(op, fn));
        @(posedge Clock); #1;
        Valid = 1'b0;
        e = dec_q.pop_front();
        check({tag, " control"}, 64'(Control), 64'(e.ctl));
        check({tag, " ctlvalid"}, 64'(CtlValid), 64'd1);
        check({tag, " illegal"}, 64'(IllegalFunct), 64'(e.ill));
        @(posedge Clock); #1;
        check({tag, " ctlvalid pulse"}, 64'(CtlValid), 64'd0);
        check({tag, " illegal pulse"}, 64'(IllegalFunct), 64'd0);
        check({tag, " control hold"}, 64'(Control), 64'(e.ctl));
        $display("alu  %-8s op=%b funct=%b control=%b illegal=%b", tag, op, fn, Control, e.ill);
    endtask

    task automatic md_op(input logic [5:0] fn, input logic [W-1:0] d1, input logic [W-1:0] d2,
                         input string tag);
        md_t        e;
        logic [3:0] ctl_before;
        int         n;
        int         stalls;
        int         exp_lat;
        @(negedge Clock);
        ctl_before = Control;
        Valid = 1'b1; ALUOp = 2'b10; Funct = fn; Data1 = d1; Data2 = d2;
        md_q.push_back(md_model(fn, d1, d2));
        @(posedge Clock); #1;
        Valid = 1'b0;
        check({tag, " no ctlvalid"}, 64'(CtlValid), 64'd0);
        n = 0;
        stalls = 0;
        while (!MdDone && n < 200) begin
            if (Stall) stalls++;
            @(posedge Clock); #1;
            n++;
        end
        e = md_q.pop_front();
        exp_lat = e.dz ? 0 : W + 1;
        check({tag, " latency"}, 64'(n), 64'(exp_lat));
        check({tag, " stall cycles"}, 64'(stalls), 64'(exp_lat));
        check({tag, " hi"}, 64'(Hi), 64'(e.hi));
        check({tag, " lo"}, 64'(Lo), 64'(e.lo));
        check({tag, " divzero"}, 64'(DivZero), 64'(e.dz));
        check({tag, " stall in done"}, 64'(Stall), 64'd0);
        check({tag, " control kept"}, 64'(Control), 64'(ctl_before));
        @(posedge Clock); #1;
        check({tag, " mddone pulse"}, 64'(MdDone), 64'd0);
        check({tag, " divzero pulse"}, 64'(DivZero), 64'd0);
        $display("md   %-8s d1=%h d2=%h hi=%h lo=%h dz=%b", tag, d1, d2, Hi, Lo, DivZero);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        md_t e;
        int  n;

        // Reset state
        repeat (2) @(posedge Clock);
        #1;
        check("reset control", 64'(Control), 64'h2);
        check("reset ctlvalid", 64'(CtlValid), 64'd0);
        check("reset stall", 64'(Stall), 64'd0);
        check("reset hi", 64'(Hi), 64'd0);
        check("reset lo", 64'(Lo), 64'd0);
        check("reset mddone", 64'(MdDone), 64'd0);
        @(negedge Clock);
        Reset_n = 1'b1;

        // Decode table and illegal funct
        alu_op(2'b10, 6'b100010, "sub");
        alu_op(2'b10, 6'b100000, "add");
        alu_op(2'b10, 6'b100100, "and");
        alu_op(2'b10, 6'b100101, "or");
        alu_op(2'b10, 6'b101010, "slt");
        alu_op(2'b10, 6'b100111, "nor");
        alu_op(2'b10, 6'b100110, "xor");
        alu_op(2'b11, 6'b000000, "ori");
        alu_op(2'b00, 6'b101010, "lw");
        alu_op(2'b01, 6'b000000, "beq");
        alu_op(2'b10, 6'b111111, "illegal");

        // Multiply / divide engine
        alu_op(2'b10, 6'b100100, "and");
        md_op(6'b011000, 32'hFFFFFFFD, 32'd7, "mult");
        md_op(6'b011010, 32'hFFFFFFF9, 32'd2, "div");
        md_op(6'b011011, 32'd7, 32'd0, "divu0");
        md_op(6'b011010, 32'd7, 32'hFFFFFFFE, "divneg");
        md_op(6'b011001, 32'hFFFFFFFF, 32'hFFFFFFFF, "multu");
        md_op(6'b011010, 32'h80000000, 32'hFFFFFFFF, "divovf");
        md_op(6'b011011, 32'd100, 32'd7, "divu");

        // Valid ignored while stalled; op in the DONE cycle is accepted
        alu_op(2'b01, 6'b000000, "beq");
        @(negedge Clock);
        Valid = 1'b1; ALUOp = 2'b10; Funct = 6'b011000; Data1 = 32'd12345; Data2 = 32'hFFFFFFFE;
        md_q.push_back(md_model(6'b011000, 32'd12345, 32'hFFFFFFFE));
        @(posedge Clock); #1;
        ALUOp = 2'b00; Funct = 6'b000000;
        n = 0;
        forever begin
            @(negedge Clock);
            if (MdDone || n >= 200) break;
            Valid = (n % 3 != 2);
            @(posedge Clock); #1;
            check("stall ctlvalid", 64'(CtlValid), 64'd0);
            check("stall control", 64'(Control), 64'h6);
            n++;
        end
        check("stall done reached", 64'(MdDone), 64'd1);
        e = md_q.pop_front();
        check("stall mult hi", 64'(Hi), 64'(e.hi));
        check("stall mult lo", 64'(Lo), 64'(e.lo));
        Valid = 1'b1; ALUOp = 2'b00;
        dec_q.push_back(dec_model(2'b00, 6'b000000));
        @(posedge Clock); #1;
        Valid = 1'b0;
        check("done-cycle add ctlvalid", 64'(CtlValid), 64'd1);
        check("done-cycle add control", 64'(Control), 64'(dec_q.pop_front().ctl));
        check("done-cycle add stall", 64'(Stall), 64'd0);
        $display("stl  held %0d cycles, add accepted in done cycle control=%b", n, Control);

        // Asynchronous reset in the middle of RUN
        alu_op(2'b01, 6'b000000, "beq");
        @(negedge Clock);
        Valid = 1'b1; ALUOp = 2'b10; Funct = 6'b011000; Data1 = 32'd9; Data2 = 32'd9;
        @(posedge Clock); #1;
        Valid = 1'b0;
        repeat (10) @(posedge Clock);
        #3;
        check("run stall before reset", 64'(Stall), 64'd1);
        Reset_n = 1'b0;
        #1;
        check("async reset stall", 64'(Stall), 64'd0);
        check("async reset hi", 64'(Hi), 64'd0);
        check("async reset lo", 64'(Lo), 64'd0);
        check("async reset control", 64'(Control), 64'h2);
        $display("rst  asserted mid-run stall=%b hi=%h lo=%h control=%b", Stall, Hi, Lo, Control);
        @(negedge Clock);
        Reset_n = 1'b1;
        md_op(6'b011000, 32'd5, 32'hFFFFFFFA, "multrst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
